conv2d_multimac: RTL and testbench

//  Parametrised successor of the single-multiplier 3x3 convolution engine.

---
 rtl/conv2d_multimac.sv | 225 ++++++++++++++++++++++
 tb/tb_conv2d_multimac.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_multimac.sv
// Valid-mode KxK convolution over a buffered PxP signed image using NMUL parallel
// multipliers, with shift, optional ReLU and saturation on each streamed result.
`timescale 1ns/1ps
module conv2d_multimac #(
  parameter int N     = 8,
  parameter int P     = 5,
  parameter int K     = 3,
  parameter int NMUL  = 1,
  parameter int SHIFT = 0,
  parameter int AW    = $clog2(P*P)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           din_valid,
  input  logic [N-1:0]   din,
  output logic           din_ready,
  input  logic [K*K*N-1:0] kernel,
  input  logic           relu_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic           busy,
  output logic           done
);

  localparam int TAPS = K*K;
  localparam int G    = (TAPS + NMUL - 1) / NMUL;
  localparam int ACCW = 2*N + $clog2(TAPS + 1);
  localparam int OW   = P - K + 1;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int CW   = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [AW-1:0] LAST_PIX = AW'(P*P - 1);
  localparam logic [GW-1:0] LAST_GRP = GW'(G - 1);
  localparam logic [CW-1:0] LAST_POS = CW'(OW - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

  // Shift, optional ReLU, then clamp into the N-bit signed range.
  function automatic logic [N-1:0] post_proc(input logic signed [ACCW-1:0] acc,
                                             input logic relu);
    logic signed [ACCW-1:0] v;
    v = acc >>> SHIFT;
    if (relu && v[ACCW-1]) begin
      v = {ACCW{1'b0}};
    end
    if (v > SAT_MAX) begin
      post_proc = SAT_MAX[N-1:0];
    end else if (v < SAT_MIN) begin
      post_proc = SAT_MIN[N-1:0];
    end else begin
      post_proc = v[N-1:0];
    end
  endfunction

  logic [2:0]             state_r;
  logic [2:0]             state_next_s;
  logic [AW-1:0]          cnt_r;
  logic [GW-1:0]          grp_r;
  logic [CW-1:0]          row_r;
  logic [CW-1:0]          col_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] group_sum_s;
  logic signed [ACCW-1:0] acc_sum_s;
  logic signed [N-1:0]    kern_r [TAPS];
  logic signed [N-1:0]    img_r [P*P];
  logic                   relu_r;
  logic [N-1:0]           result_r;
  logic                   out_valid_r;
  logic                   din_ready_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   last_pix_s;
  logic                   last_grp_s;
  logic                   last_pos_s;
  int                     tap_s;
  int                     addr_s;
  logic signed [N-1:0]    pix_s;
  logic signed [N-1:0]    coef_s;
  logic signed [2*N-1:0]  prod_s;

  assign last_pix_s = (cnt_r == LAST_PIX);
  assign last_grp_s = (grp_r == LAST_GRP);
  assign last_pos_s = (row_r == LAST_POS) && (col_r == LAST_POS);

  // Next-state decode; outputs are registered from this so they line up with the state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  state_next_s = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_next_s = (din_valid && last_pix_s) ? S_MAC : S_LOAD;
      S_MAC:   state_next_s = last_grp_s ? S_OUT : S_MAC;
      S_OUT: begin
        if (out_ready) begin
          state_next_s = last_pos_s ? S_FIN : S_MAC;
        end else begin
          state_next_s = S_OUT;
        end
      end
      S_FIN:   state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Sum of one tap group; taps past K*K fall outside the kernel and contribute nothing.
  always_comb begin
    group_sum_s = {ACCW{1'b0}};
    tap_s       = 0;
    addr_s      = 0;
    pix_s       = {N{1'b0}};
    coef_s      = {N{1'b0}};
    prod_s      = {(2*N){1'b0}};
    for (int j = 0; j < NMUL; j++) begin
      tap_s = int'(grp_r) * NMUL + j;
      if (tap_s < TAPS) begin
        addr_s      = (int'(row_r) + tap_s / K) * P + int'(col_r) + tap_s % K;
        pix_s       = img_r[addr_s[AW-1:0]];
        coef_s      = kern_r[tap_s];
        prod_s      = (2*N)'(pix_s) * (2*N)'(coef_s);
        group_sum_s = group_sum_s + ACCW'(prod_s);
      end else begin
        group_sum_s = group_sum_s;
      end
    end
    acc_sum_s = ((grp_r == {GW{1'b0}}) ? {ACCW{1'b0}} : acc_r) + group_sum_s;
  end

  // Image buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_r == S_LOAD && din_valid) begin
      img_r[cnt_r] <= din;
    end
  end

  // FSM, counters, accumulator, sampled configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {AW{1'b0}};
      grp_r       <= {GW{1'b0}};
      row_r       <= {CW{1'b0}};
      col_r       <= {CW{1'b0}};
      acc_r       <= {ACCW{1'b0}};
      relu_r      <= 1'b0;
      result_r    <= {N{1'b0}};
      out_valid_r <= 1'b0;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        kern_r[i] <= {N{1'b0}};
      end
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == S_OUT);
      din_ready_r <= (state_next_s == S_LOAD);
      busy_r      <= (state_next_s != S_IDLE);
      done_r      <= (state_next_s == S_FIN);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            relu_r <= relu_en;
            cnt_r  <= {AW{1'b0}};
            for (int i = 0; i < TAPS; i++) begin
              kern_r[i] <= kernel[i*N +: N];
            end
          end
        end
        S_LOAD: begin
          if (din_valid) begin
            if (last_pix_s) begin
              cnt_r <= {AW{1'b0}};
              grp_r <= {GW{1'b0}};
              row_r <= {CW{1'b0}};
              col_r <= {CW{1'b0}};
              acc_r <= {ACCW{1'b0}};
            end else begin
              cnt_r <= cnt_r + AW'(1);
            end
          end
        end
        S_MAC: begin
          acc_r <= acc_sum_s;
          if (last_grp_s) begin
            result_r <= post_proc(acc_sum_s, relu_r);
            grp_r    <= {GW{1'b0}};
          end else begin
            grp_r <= grp_r + GW'(1);
          end
        end
        S_OUT: begin
          // Advance row-major only once the result has been taken.
          if (out_ready && !last_pos_s) begin
            if (col_r == LAST_POS) begin
              col_r <= {CW{1'b0}};
              row_r <= row_r + CW'(1);
            end else begin
              col_r <= col_r + CW'(1);
            end
          end
        end
        S_FIN: begin
          acc_r <= {ACCW{1'b0}};
        end
        default: begin
          acc_r <= {ACCW{1'b0}};
        end
      endcase
    end
  end

  assign din_ready = din_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv2d_multimac.sv
// Scoreboard bench for conv2d_multimac: a direct-sum reference model fills a queue,
// and a monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_conv2d_multimac;
  localparam int N = 8, P = 5, K = 3, NMUL = 4, SHIFT = 0;
  localparam int TAPS = K*K;
  localparam int G    = (TAPS + NMUL - 1) / NMUL;
  localparam int OW   = P - K + 1;
  localparam int NOUT = OW*OW;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, din_valid = 1'b0;
  logic [N-1:0] din = '0;
  logic din_ready;
  logic [TAPS*N-1:0] kernel = '0;
  logic relu_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [N-1:0] result;
  logic busy, done;

  conv2d_multimac #(.N(N), .P(P), .K(K), .NMUL(NMUL), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .kernel(kernel), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;
  logic signed [N-1:0] img_m [P*P];
  logic signed [N-1:0] kern_m [TAPS];
  logic signed [N-1:0] exp_q [$];
  int  rmode = 0, rphase = 0;
  int  hs_run = 0, last_hs_cyc = 0, first_ov_cyc = -1, done_run = 0, last_load_cyc = 0;
  bit  stall_prev = 1'b0;
  logic [N-1:0] prev_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Reference: direct valid-mode convolution, then shift/ReLU/clamp.
  task automatic push_expected(input bit relu);
    longint s;
    for (int orow = 0; orow < OW; orow++)
      for (int ocol = 0; ocol < OW; ocol++) begin
        s = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            s += longint'(img_m[(orow + r)*P + ocol + c]) * longint'(kern_m[r*K + c]);
        s = s >>> SHIFT;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        exp_q.push_back(N'(s));
      end
  endtask

  // out_ready pattern generator: always on, 1-on/3-off, or random.
  initial begin
    forever begin
      @(posedge clk); #1;
      rphase = rphase + 1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (rphase % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every handshake with the scoreboard, plus stall and timing rules.
  always @(negedge clk) begin
    logic signed [N-1:0] e;
    if (rst) begin
      if (out_valid) begin
        if (first_ov_cyc < 0) begin
          first_ov_cyc = cyc;
          check(cyc - last_load_cyc == G, "first_latency", cyc - last_load_cyc, G);
        end
        if (stall_prev)
          check(result == prev_res, "stall_stable", longint'($signed(result)), longint'($signed(prev_res)));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", longint'($signed(result)), 0);
          end else begin
            e = exp_q.pop_front();
            check($signed(result) == e, "result", longint'($signed(result)), longint'(e));
          end
          if (rmode == 0 && hs_run > 0)
            check(cyc - last_hs_cyc == G + 1, "spacing", cyc - last_hs_cyc, G + 1);
          hs_run++;
          last_hs_cyc = cyc;
        end
        stall_prev = !out_ready;
        prev_res   = result;
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        done_run++;
        check(cyc == last_hs_cyc + 1, "done_timing", cyc - last_hs_cyc, 1);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic start_and_load(input bit relu, input bit gaps);
    for (int i = 0; i < TAPS; i++) kernel[i*N +: N] = kern_m[i];
    relu_en = relu;
    hs_run = 0; done_run = 0; first_ov_cyc = -1; last_hs_cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check(din_ready == 1'b1, "din_ready_load", din_ready, 1);
    check(busy == 1'b1, "busy_load", busy, 1);
    for (int p = 0; p < P*P; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
      din_valid = 1'b1;
      din = img_m[p];
      if (p == 12) begin
        // start while busy plus new config: both must be ignored.
        start = 1'b1;
        relu_en = !relu;
        for (int i = 0; i < TAPS; i++) kernel[i*N +: N] = 8'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (p == P*P - 1) last_load_cyc = cyc;
    end
    din_valid = 1'b0;
  endtask

  task automatic run_image(input int mode, input bit relu);
    rmode = mode;
    push_expected(relu);
    start_and_load(relu, 1'b1);
    for (int t = 0; t < 3000 && done_run == 0; t++) begin
      @(posedge clk); #1;
    end
    check(done_run == 1, "done_seen", done_run, 1);
    repeat (3) @(posedge clk);
    #1;
    check(done_run == 1, "done_once", done_run, 1);
    check(exp_q.size() == 0, "outputs_left", exp_q.size(), 0);
    check(hs_run == NOUT, "output_count", hs_run, NOUT);
    check(busy == 1'b0, "idle_after_run", busy, 0);
    exp_q.delete();
  endtask

  task automatic fill(input int pv, input int kv);
    for (int i = 0; i < P*P; i++) img_m[i] = N'(pv);
    for (int i = 0; i < TAPS; i++) kern_m[i] = N'(kv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(din_ready == 1'b0, "rst_din_ready", din_ready, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(result == '0, "rst_result", result, 0);
    @(negedge clk) rst = 1'b1;

    fill(1, 1);          run_image(0, 1'b0);
    fill(127, 127);      run_image(0, 1'b0);
    fill(127, -128);     run_image(0, 1'b0);
    for (int i = 0; i < P*P; i++) img_m[i] = N'(i);
    for (int i = 0; i < TAPS; i++) kern_m[i] = (i == TAPS/2) ? -8'sd1 : 8'sd0;
    run_image(0, 1'b1);
    run_image(0, 1'b0);
    fill(1, 1);          run_image(1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < P*P; i++) img_m[i] = 8'($urandom);
      for (int i = 0; i < TAPS; i++) kern_m[i] = 8'($urandom_range(0, 15)) - 8'sd8;
      run_image(2, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the fifth output's MAC phase.
    fill(1, 1);
    rmode = 0;
    push_expected(1'b0);
    start_and_load(1'b0, 1'b0);
    for (int t = 0; t < 500 && hs_run < 4; t++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    #1;
    check(hs_run == 4, "abort_hs_count", hs_run, 4);
    check(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
    check(busy == 1'b0, "abort_busy", busy, 0);
    check(done == 1'b0, "abort_done", done, 0);
    check(din_ready == 1'b0, "abort_din_ready", din_ready, 0);
    check(result == '0, "abort_result", result, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check(busy == 1'b0, "post_rst_idle", busy, 0);
    fill(1, 1);          run_image(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
